// File: rtl/trigger_sequencer.sv
// Multi-line trigger engine: per-line level/edge qualification, OR/AND combining,
// pre/post sample windows, abort, auto-rearm and a saturating trigger counter.
module trigger_sequencer #(
    parameter int unsigned NUM_TRIGGER_LINES = 4,
    parameter int unsigned COUNT_W           = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           arm,
    input  logic                           abort,
    input  logic [NUM_TRIGGER_LINES-1:0]   triggers,
    input  logic [NUM_TRIGGER_LINES-1:0]   mask,
    input  logic [2*NUM_TRIGGER_LINES-1:0] mode,
    input  logic                           combine,
    input  logic [COUNT_W-1:0]             pre_count,
    input  logic [COUNT_W-1:0]             post_count,
    input  logic                           auto_rearm,
    output logic [2:0]                     trigger_state,
    output logic                           busy,
    output logic                           trig_pulse,
    output logic                           done,
    output logic [COUNT_W-1:0]             trig_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [NUM_TRIGGER_LINES-1:0]   trig_q, trig_qq;
    logic [NUM_TRIGGER_LINES-1:0]   mask_r;
    logic [2*NUM_TRIGGER_LINES-1:0] mode_r;
    logic                           combine_r;
    logic [COUNT_W-1:0]             post_r;
    logic [COUNT_W-1:0]             cnt, cnt_nx;
    logic [NUM_TRIGGER_LINES-1:0]   line_hit;
    logic                           match;
    logic                           start;
    logic                           load_cfg;
    logic                           pulse_nx, done_nx, count_inc, busy_nx;

    always_comb begin
        line_hit = '0;
        for (int unsigned i = 0; i < NUM_TRIGGER_LINES; i++) begin
            case (mode_r[2*i +: 2])
                2'b00:   line_hit[i] = trig_q[i];
                2'b01:   line_hit[i] = ~trig_q[i];
                2'b10:   line_hit[i] = trig_q[i] & ~trig_qq[i];
                default: line_hit[i] = ~trig_q[i] & trig_qq[i];
            endcase
        end
    end

    // An empty mask must never match, including in AND mode where the reduction would be vacuously true.
    assign match = (|mask_r) &&
                   (combine_r ? (&(line_hit | ~mask_r)) : (|(line_hit & mask_r)));

    assign start = ((state == S_IDLE) && arm) ||
                   ((state == S_DONE) && (arm || auto_rearm));

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        load_cfg  = 1'b0;
        pulse_nx  = 1'b0;
        done_nx   = 1'b0;
        count_inc = 1'b0;

        case (state)
            S_IDLE: ;
            S_PRE: begin
                if (cnt <= COUNT_W'(1)) begin
                    state_nx = S_ARMED;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - COUNT_W'(1);
                end
            end
            S_ARMED: begin
                if (match) begin
                    pulse_nx  = 1'b1;
                    count_inc = 1'b1;
                    if (post_r == '0) begin
                        state_nx = S_DONE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = S_POST;
                        cnt_nx   = post_r;
                    end
                end
            end
            S_POST: begin
                if (cnt <= COUNT_W'(1)) begin
                    state_nx = S_DONE;
                    done_nx  = 1'b1;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - COUNT_W'(1);
                end
            end
            S_DONE: ;
            default: state_nx = S_IDLE;
        endcase

        if (start) begin
            load_cfg = 1'b1;
            cnt_nx   = pre_count;
            state_nx = (pre_count == '0) ? S_ARMED : S_PRE;
        end

        if (abort) begin
            state_nx  = S_IDLE;
            cnt_nx    = '0;
            load_cfg  = 1'b0;
            pulse_nx  = 1'b0;
            done_nx   = 1'b0;
            count_inc = 1'b0;
        end

        busy_nx = (state_nx == S_PRE) || (state_nx == S_ARMED) || (state_nx == S_POST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            trig_q     <= '0;
            trig_qq    <= '0;
            mask_r     <= '0;
            mode_r     <= '0;
            combine_r  <= 1'b0;
            post_r     <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            trig_pulse <= 1'b0;
            done       <= 1'b0;
            trig_count <= '0;
        end else begin
            trig_q     <= triggers;
            trig_qq    <= trig_q;
            state      <= state_nx;
            cnt        <= cnt_nx;
            busy       <= busy_nx;
            trig_pulse <= pulse_nx;
            done       <= done_nx;
            if (load_cfg) begin
                mask_r    <= mask;
                mode_r    <= mode;
                combine_r <= combine;
                post_r    <= post_count;
            end
            if (count_inc && (trig_count != '1))
                trig_count <= trig_count + COUNT_W'(1);
        end
    end

    assign trigger_state = state;

endmodule
